// File: rtl/vr_input_conditioner.sv
// VR/hall input conditioner: synchronizer, stable-sample glitch filter,
// adaptive tooth-edge lockout, tooth period measurement and stall detection.
module vr_input_conditioner #(
  parameter int          SYNC_STAGES   = 2,
  parameter int          PERIOD_W      = 32,
  parameter logic [31:0] STALL_TIMEOUT = 32'd10_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vrin,
  input  logic [7:0]          conf_filter_len,
  input  logic [1:0]          conf_lockout_shift,
  input  logic                conf_edge_pol,
  output logic                vr_clean,
  output logic                tooth_edge,
  output logic [PERIOD_W-1:0] tooth_period,
  output logic                period_valid,
  output logic [15:0]         reject_cnt,
  output logic                stalled,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    ST_STALLED = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_RUNNING = 2'd2
  } state_t;

  localparam logic [PERIOD_W:0] STALL_LIM = (PERIOD_W+1)'(STALL_TIMEOUT);

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [7:0]             fcnt;
  logic [8:0]             fcnt_p1;
  logic [7:0]             filt_len;
  logic                   rej_hold;
  logic                   differ;
  logic                   eval;
  logic                   active_going;

  logic [PERIOD_W-1:0]    pcnt;
  logic [PERIOD_W:0]      pcnt_p1;
  logic [PERIOD_W-1:0]    meas;
  logic [PERIOD_W-1:0]    hist0, hist1;
  logic [PERIOD_W-1:0]    hist_min;
  logic [PERIOD_W:0]      window;
  logic [2:0]             shift_amt;

  logic lockout_en, timeout_en;
  logic cand_edge, lockout_hit, accept, reject, timeout;

  // ---------------- input synchronizer ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], vrin};
  end
  assign s = sync_q[SYNC_STAGES-1];

  // ---------------- filter / qualification terms ----------------
  always_comb begin
    filt_len     = (conf_filter_len == 8'd0) ? 8'd1 : conf_filter_len;
    fcnt_p1      = {1'b0, fcnt} + 9'd1;
    differ       = (s != vr_clean);
    // A rejected candidate stays parked until the input goes inactive again.
    eval         = differ && !rej_hold && (fcnt_p1 >= {1'b0, filt_len});
    active_going = (s == conf_edge_pol);

    pcnt_p1      = {1'b0, pcnt} + {{PERIOD_W{1'b0}}, 1'b1};
    meas         = pcnt_p1[PERIOD_W] ? '1 : pcnt_p1[PERIOD_W-1:0];
    hist_min     = (hist0 < hist1) ? hist0 : hist1;
    shift_amt    = {1'b0, conf_lockout_shift} + 3'd1;
    window       = {1'b0, hist_min} >> shift_amt;

    cand_edge    = eval && active_going;
    lockout_hit  = lockout_en && (pcnt_p1 < window);
    accept       = cand_edge && !lockout_hit;
    reject       = cand_edge && lockout_hit;
    timeout      = timeout_en && (pcnt_p1 >= STALL_LIM) && !accept;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_STALLED;
    else          state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STALLED: if (accept) state_nxt = ST_ACQUIRE;
      ST_ACQUIRE: begin
        if (accept)       state_nxt = ST_RUNNING;
        else if (timeout) state_nxt = ST_STALLED;
      end
      ST_RUNNING: begin
        if (timeout)      state_nxt = ST_STALLED;
      end
      default:            state_nxt = ST_STALLED;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    lockout_en = 1'b0;
    timeout_en = 1'b0;
    stalled    = 1'b0;
    case (state)
      ST_STALLED: stalled    = 1'b1;
      ST_ACQUIRE: timeout_en = 1'b1;
      ST_RUNNING: begin
        lockout_en = 1'b1;
        timeout_en = 1'b1;
      end
      default:    stalled    = 1'b1;
    endcase
    state_dbg = state;
  end

  // ---------------- glitch filter and clean level ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt       <= 8'd0;
      rej_hold   <= 1'b0;
      vr_clean   <= 1'b0;
      tooth_edge <= 1'b0;
      reject_cnt <= 16'd0;
    end else begin
      if (!differ || rej_hold || eval) fcnt <= 8'd0;
      else                             fcnt <= fcnt_p1[7:0];

      if (!differ)     rej_hold <= 1'b0;
      else if (reject) rej_hold <= 1'b1;

      // Inactive-going changes always pass; active-going ones only if accepted.
      if (eval && (!active_going || accept)) vr_clean <= s;

      tooth_edge <= accept;

      if (reject && (reject_cnt != 16'hFFFF)) reject_cnt <= reject_cnt + 16'd1;
    end
  end

  // ---------------- period measurement ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt         <= '0;
      hist0        <= '0;
      hist1        <= '0;
      tooth_period <= '0;
      period_valid <= 1'b0;
    end else begin
      if (accept)       pcnt <= '0;
      else if (!(&pcnt)) pcnt <= pcnt_p1[PERIOD_W-1:0];

      if (accept) begin
        case (state)
          ST_ACQUIRE: begin
            tooth_period <= meas;
            hist0        <= meas;
            hist1        <= meas;
            period_valid <= 1'b1;
          end
          ST_RUNNING: begin
            hist1        <= hist0;
            hist0        <= meas;
            tooth_period <= meas;
          end
          default: ;
        endcase
      end else if (timeout) begin
        period_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vr_input_conditioner.sv
// Bench for vr_input_conditioner: directed glitch/period/lockout/stall/reset
// steps plus randomized tooth streams checked against an event-time model.
module tb_vr_input_conditioner;

  localparam int          SYNC = 2;
  localparam int          PW   = 32;
  localparam logic [31:0] TMO  = 32'd5000;

  logic          clk;
  logic          reset_n;
  logic          vrin;
  logic [7:0]    conf_filter_len;
  logic [1:0]    conf_lockout_shift;
  logic          conf_edge_pol;
  logic          vr_clean;
  logic          tooth_edge;
  logic [PW-1:0] tooth_period;
  logic          period_valid;
  logic [15:0]   reject_cnt;
  logic          stalled;
  logic [1:0]    state_dbg;

  vr_input_conditioner #(
    .SYNC_STAGES  (SYNC),
    .PERIOD_W     (PW),
    .STALL_TIMEOUT(TMO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .vrin              (vrin),
    .conf_filter_len   (conf_filter_len),
    .conf_lockout_shift(conf_lockout_shift),
    .conf_edge_pol     (conf_edge_pol),
    .vr_clean          (vr_clean),
    .tooth_edge        (tooth_edge),
    .tooth_period      (tooth_period),
    .period_valid      (period_valid),
    .reject_cnt        (reject_cnt),
    .stalled           (stalled),
    .state_dbg         (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] c;
    logic        acc;
    logic [31:0] tp;
    logic        pv;
    logic [15:0] rej;
    logic        stl;
  } exp_t;

  exp_t exp_q[$];
  logic wave_q[$];
  int   t;
  int   vec_cnt, err_cnt;
  int   leff, shift_r;
  logic pol;
  logic chk_low;

  // reference model: event times of accepted edges
  int m_n, m_last, m_h0, m_h1, m_tp, m_pv, m_rej;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, expv, t);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic model_reset();
    m_n = 0; m_last = 0; m_h0 = 0; m_h1 = 0; m_tp = 0; m_pv = 0; m_rej = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    t = 0;
    wave_q.delete();
    exp_q.delete();
    chk_low = 1'b0;
    model_reset();
  endtask

  // Tooth candidate at clock c: decide acceptance from periods between edges.
  task automatic model_eval(input int c);
    int   per, mn, win;
    logic acc;
    exp_t e;
    per = c - m_last;
    if (m_n > 0 && per > int'(TMO)) begin
      m_n = 0;
      m_pv = 0;
    end
    acc = 1'b1;
    if (m_n == 0) begin
      m_n = 1;
    end else if (m_n == 1) begin
      m_tp = per; m_h0 = per; m_h1 = per; m_pv = 1; m_n = 2;
    end else begin
      mn  = (m_h0 < m_h1) ? m_h0 : m_h1;
      win = mn >> (shift_r + 1);
      if (per < win) acc = 1'b0;
      else begin
        m_h1 = m_h0; m_h0 = per; m_tp = per;
      end
    end
    if (acc) m_last = c;
    else begin
      if (m_rej < 65535) m_rej++;
      if (per >= int'(TMO)) begin
        m_n = 0;
        m_pv = 0;
      end
    end
    e.c   = c;
    e.acc = acc;
    e.tp  = m_tp;
    e.pv  = (m_pv != 0);
    e.rej = 16'(m_rej);
    e.stl = (m_n == 0);
    exp_q.push_back(e);
  endtask

  // Active pulse on vrin starting at time rise (absolute, since reset).
  task automatic add_pulse(input int rise, input int hi, input bit cand);
    while (wave_q.size() < rise) wave_q.push_back(1'b0);
    repeat (hi) wave_q.push_back(1'b1);
    if (cand) model_eval(rise + SYNC + leff);
  endtask

  task automatic play_to(input int t_end);
    exp_t e;
    while (t < t_end) begin
      vrin = (t < wave_q.size()) ? (wave_q[t] ? pol : !pol) : !pol;
      tick();
      if (chk_low) begin
        check("edge_one_cycle", {31'd0, tooth_edge}, 32'd0);
        chk_low = 1'b0;
      end
      if (exp_q.size() > 0 && exp_q[0].c == t) begin
        e = exp_q.pop_front();
        check("tooth_edge",   {31'd0, tooth_edge},   {31'd0, e.acc});
        check("vr_clean",     {31'd0, vr_clean},     {31'd0, e.acc ? pol : !pol});
        check("tooth_period", tooth_period,          e.tp);
        check("period_valid", {31'd0, period_valid}, {31'd0, e.pv});
        check("reject_cnt",   {16'd0, reject_cnt},   {16'd0, e.rej});
        check("stalled",      {31'd0, stalled},      {31'd0, e.stl});
        chk_low = e.acc;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_stalled"},  {31'd0, stalled},      32'd1);
    check({tag, "_vr_clean"}, {31'd0, vr_clean},     32'd0);
    check({tag, "_tp"},       tooth_period,          32'd0);
    check({tag, "_pv"},       {31'd0, period_valid}, 32'd0);
    check({tag, "_rej"},      {16'd0, reject_cnt},   32'd0);
    check({tag, "_edge"},     {31'd0, tooth_edge},   32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   n, rise, per, x;
    logic saw;
    vec_cnt = 0; err_cnt = 0; t = 0;
    pol = 1'b1; leff = 4; shift_r = 0;
    vrin = 1'b0; reset_n = 1'b0;
    conf_filter_len = 8'd4; conf_lockout_shift = 2'd0; conf_edge_pol = 1'b1;
    #1;
    check_reset_vals("por");
    do_reset();
    check_reset_vals("post_reset");

    // Glitch filter: 3-cycle pulse ignored, 4-cycle level accepted after 6 clocks.
    play_to(20);
    vrin = 1'b1;
    repeat (3) tick();
    vrin = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      tick();
      if (vr_clean || tooth_edge) saw = 1'b1;
    end
    check("glitch_ignored", {31'd0, saw}, 32'd0);
    vrin = 1'b1;
    n = 0;
    while (!vr_clean && n < 20) begin
      tick();
      n++;
    end
    check("filter_latency", n, 32'd6);
    check("glitch_edge_hi", {31'd0, tooth_edge}, 32'd1);
    tick();
    check("glitch_edge_lo", {31'd0, tooth_edge}, 32'd0);
    vrin = 1'b0;
    repeat (10) tick();
    check("glitch_fall", {31'd0, vr_clean}, 32'd0);

    // Period, lockout and missing tooth: L=2, shift=0, 1000-cycle teeth.
    conf_filter_len = 8'd2; leff = 2;
    do_reset();
    add_pulse(100, 20, 1);
    add_pulse(1100, 20, 1);
    add_pulse(2100, 20, 1);
    add_pulse(2400, 20, 1);
    add_pulse(3100, 20, 1);
    add_pulse(4100, 20, 1);
    add_pulse(7100, 20, 1);
    add_pulse(8100, 20, 1);
    play_to(8200);
    check("dir_rej_cnt", {16'd0, reject_cnt}, 32'd1);
    check("dir_period", tooth_period, 32'd1000);
    check("dir_pv", {31'd0, period_valid}, 32'd1);

    // Stall exactly TMO clocks after the last accepted edge (clock 8104).
    play_to(8104 + int'(TMO) - 1);
    check("pre_stall", {31'd0, stalled}, 32'd0);
    play_to(8104 + int'(TMO));
    check("stall", {31'd0, stalled}, 32'd1);
    check("stall_pv", {31'd0, period_valid}, 32'd0);
    check("stall_tp_kept", tooth_period, 32'd1000);
    add_pulse(15000, 20, 1);
    add_pulse(15800, 20, 1);
    play_to(15900);
    check("reacq_period", tooth_period, 32'd800);
    check("reacq_pv", {31'd0, period_valid}, 32'd1);
    check("dir_drained", exp_q.size(), 32'd0);

    // Asynchronous reset mid-run with vrin toggling.
    #2 vrin = ~vrin;
    #1 reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (3) begin
      #3 vrin = ~vrin;
      @(posedge clk);
    end
    #1;
    check_reset_vals("rst_held");

    // Randomized tooth streams with missing teeth, early pulses and glitches.
    for (int seg = 0; seg < 3; seg++) begin
      pol = 1'($urandom_range(0, 1));
      conf_edge_pol = pol;
      conf_filter_len = 8'($urandom_range(0, 8));
      leff = (conf_filter_len == 8'd0) ? 1 : int'(conf_filter_len);
      shift_r = $urandom_range(0, 3);
      conf_lockout_shift = 2'(shift_r);
      vrin = !pol;
      do_reset();
      rise = 100;
      for (int k = 0; k < 12; k++) begin
        per = $urandom_range(300, 700);
        if ($urandom_range(0, 5) == 0) per = per * 3;
        add_pulse(rise, leff + 8, 1);
        if (leff >= 2 && $urandom_range(0, 2) == 0) add_pulse(rise + 35, leff - 1, 0);
        if ($urandom_range(0, 3) == 0) begin
          x = $urandom_range(60, per - 60);
          add_pulse(rise + x, leff + 8, 1);
        end
        rise = rise + per;
      end
      play_to(rise + 100);
      check("rand_drained", exp_q.size(), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vr_input_conditioner.md
Name: vr_input_conditioner

Overview:
Conditions the raw VR/hall comparator output before it reaches the crank synchronizer. Stages:
- synchronizes the asynchronous input into the clk domain;
- rejects glitches with a programmable stable-sample filter;
- rejects early edges with an adaptive lockout window derived from recent tooth periods;
- measures tooth period in clk cycles.

vr_clean feeds the synchronizer's vrin input. tooth_edge, tooth_period and stalled are available for diagnostics and SPI readback.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the input synchronizer (min 2).
PERIOD_W, 32, width of the period counter and tooth_period.
STALL_TIMEOUT, 32'd10_000_000, clk cycles without an accepted edge before the engine is declared stalled.

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
vrin  in  1  raw comparator output, asynchronous to clk
conf_filter_len  in  8  consecutive stable cycles needed to accept a level change; 0 treated as 1
conf_lockout_shift  in  2  lockout = min(last two periods) >> (conf_lockout_shift+1), i.e. 1/2, 1/4, 1/8, 1/16
conf_edge_pol  in  1  1 = rising edge is the tooth edge, 0 = falling
vr_clean  out  1  filtered, lockout-qualified level
tooth_edge  out  1  one-cycle pulse per accepted tooth edge
tooth_period  out  PERIOD_W  cycles between the last two accepted edges
period_valid  out  1  tooth_period holds a real measurement
reject_cnt  out  16  saturating count of edges rejected by lockout
stalled  out  1  no accepted edge within STALL_TIMEOUT

Behaviour:
- Async reset values: sync chain 0, vr_clean 0, tooth_edge 0, tooth_period 0, period_valid 0, reject_cnt 0, stalled 1, filter count 0, period counter 0, both period history regs 0, state STALLED.
- Synchronizer: SYNC_STAGES flops; its output is s.
- Glitch filter:
  - fcnt counts consecutive cycles with s != vr_clean and clears whenever s == vr_clean.
  - When fcnt+1 >= max(conf_filter_len,1), the candidate transition is evaluated on that clock, then fcnt clears.
  - Latency from a vrin change to vr_clean = SYNC_STAGES + L cycles, where L = max(conf_filter_len,1).
- Candidate qualification:
  - Inactive-going transitions (level opposite conf_edge_pol) are always applied to vr_clean.
  - An active-going transition is a tooth edge candidate.
  - If it is accepted, vr_clean updates and tooth_edge = 1 for exactly that cycle.
  - If it is rejected, vr_clean does not change, fcnt clears, and reject_cnt increments, saturating at 16'hFFFF.
  - After a rejection, vr_clean stays inactive until s returns to inactive and then becomes active again for L cycles.
- Period counter pcnt:
  - Clears to 0 on the cycle of an accepted edge; otherwise increments, saturating at all-ones.
  - The measured period at an edge is pcnt+1.
- States:
  - STALLED: no lockout. Accepted edge -> ACQUIRE, stalled clears. tooth_period and period_valid are unchanged.
  - ACQUIRE: no lockout. Accepted edge -> RUNNING; tooth_period = pcnt+1; both history regs = pcnt+1; period_valid = 1.
  - RUNNING: a candidate is rejected when pcnt+1 < (min(hist0,hist1) >> (conf_lockout_shift+1)). Accepted edge: hist1 = hist0, hist0 = pcnt+1, tooth_period = pcnt+1.
  - Using the minimum of two periods keeps the tooth after a missing-tooth gap from being locked out.
- Timeout:
  - In ACQUIRE or RUNNING, if pcnt+1 >= STALL_TIMEOUT with no accepted edge that cycle -> STALLED, stalled = 1, period_valid = 0.
  - An accepted edge in the same cycle wins over the timeout.
- Config inputs are used live every cycle; a change takes effect on the next evaluation with no resync.
- Reset asserted mid-operation returns all state to reset values immediately; outputs are valid again from the first clk after deassertion.

Test Plan:
1. Reset: assert reset_n=0 mid-run with vrin toggling -> stalled=1, vr_clean=0, tooth_period=0, period_valid=0, reject_cnt=0, all immediately and asynchronously.
2. Glitch: L=4, pol=1, vrin high for 3 cycles -> no vr_clean or tooth_edge change; high for 4 cycles -> vr_clean rises 6 cycles after vrin (SYNC_STAGES=2), with a single-cycle tooth_edge.
3. Period: L=2, clean edges every 1000 cycles -> first edge: period_valid stays 0; second: tooth_period=1000, period_valid=1; third: RUNNING, tooth_period=1000.
4. Lockout: RUNNING at 1000-cycle period, shift=0 (window 500), extra edge 300 cycles after a tooth -> no tooth_edge, reject_cnt=1; next real edge at 1000 -> tooth_period=1000.
5. Missing tooth: periods 1000,1000,3000,1000 with shift=0 -> all edges accepted, tooth_period sequence 1000,1000,3000,1000, reject_cnt=0.
6. Stall: STALL_TIMEOUT=5000, edges stop -> exactly 5000 cycles after the last edge stalled=1, period_valid=0. Next edge -> ACQUIRE with tooth_period unchanged; the following edge restores period_valid.
